// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
//   Round-robin arbiter sharing one AXI write path (AW/W/B) between NREQ DMA
//   requesters. One transaction is outstanding at a time: grant, one AW beat,
//   len+1 W beats with WLAST generated locally, then one B response routed
//   back to the granted requester as a done pulse.
//
// Optional feature macro: AXI_WR_ARB_TIMEOUT_EN
//   When defined, a watchdog in RESP completes the transaction with SLVERR
//   after TIMEOUT consecutive cycles without BVALID. When undefined, RESP
//   waits indefinitely and no counter exists.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester request / one-cycle grant pulse
//   req_addr/len/burst per-requester transaction description (packed slices)
//   wr_valid/data/ready per-requester write data stream
//   done_valid/resp   per-requester completion pulse and shared response
//   AW*/W*/B*         AXI write master channels
//   busy              arbiter not idle
//   grant_idx         current or last granted requester
module axi_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 64,
  parameter int IDWIDTH = 4,
  parameter int TIMEOUT = 256,
  localparam int GW     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*4-1:0]        req_len,
  input  logic [NREQ-1:0]          req_burst,
  input  logic [NREQ-1:0]          wr_valid,
  input  logic [NREQ*DWIDTH-1:0]   wr_data,
  output logic [NREQ-1:0]          wr_ready,
  output logic [NREQ-1:0]          done_valid,
  output logic [1:0]               done_resp,
  output logic                     AWVALID,
  input  logic                     AWREADY,
  output logic [AWIDTH-1:0]        AWADDR,
  output logic [3:0]               AWLEN,
  output logic [1:0]               AWBURST,
  output logic [IDWIDTH-1:0]       AWID,
  output logic                     WVALID,
  input  logic                     WREADY,
  output logic [DWIDTH-1:0]        WDATA,
  output logic                     WLAST,
  output logic [IDWIDTH-1:0]       WID,
  input  logic                     BVALID,
  output logic                     BREADY,
  input  logic [1:0]               BRESP,
  input  logic [IDWIDTH-1:0]       BID,
  output logic                     busy,
  output logic [GW-1:0]            grant_idx
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("axi_wr_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       rr_ptr_q;
  logic [3:0]          beat_cnt_q;
  logic [NREQ-1:0]     req_ready_q;
  logic [NREQ-1:0]     done_valid_q;
  logic [1:0]          done_resp_q;
  logic                awvalid_q;
  logic [AWIDTH-1:0]   awaddr_q;
  logic [3:0]          awlen_q;
  logic [1:0]          awburst_q;
  logic [IDWIDTH-1:0]  awid_q;

  logic [AWIDTH-1:0]   addr_a [NREQ];
  logic [3:0]          len_a  [NREQ];
  logic [DWIDTH-1:0]   data_a [NREQ];

  logic                pick_vld;
  logic [GW-1:0]       pick_idx;
  logic [GW-1:0]       cand;
  logic                w_hs;
  logic                to_fire;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AWIDTH +: AWIDTH];
    assign len_a[i]  = req_len[i*4 +: 4];
    assign data_a[i] = wr_data[i*DWIDTH +: DWIDTH];
  end

  // Rotating priority: scan from farthest to nearest so the first set bit
  // after rr_ptr (with wrap) is the one left in pick_idx.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts consecutive RESP cycles without BVALID; cleared everywhere else.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == RESP && !BVALID) to_cnt_d = to_cnt_q + 1'b1;
  end

  assign to_fire = (state_q == RESP) && !BVALID && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pick_vld) state_d = ADDR;
      ADDR: if (AWREADY) state_d = DATA;
      DATA: if (w_hs && beat_cnt_q == 4'd0) state_d = RESP;
      RESP: if (BVALID || to_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs: W path is a pass-through mux only while in DATA.
  always_comb begin
    WVALID   = 1'b0;
    WDATA    = '0;
    WLAST    = 1'b0;
    WID      = '0;
    wr_ready = '0;
    if (state_q == DATA) begin
      WVALID            = wr_valid[grant_q];
      WDATA             = data_a[grant_q];
      WLAST             = (beat_cnt_q == 4'd0);
      WID               = IDWIDTH'(grant_q);
      wr_ready[grant_q] = WREADY;
    end
    BREADY = (state_q == RESP);
    busy   = (state_q != IDLE);
  end

  assign w_hs = WVALID & WREADY;

  // Registered grant, AW channel, beat counter and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= '0;
      rr_ptr_q     <= GW'(NREQ - 1);
      beat_cnt_q   <= '0;
      req_ready_q  <= '0;
      done_valid_q <= '0;
      done_resp_q  <= '0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awburst_q    <= '0;
      awid_q       <= '0;
    end else begin
      req_ready_q  <= '0;
      done_valid_q <= '0;
      done_resp_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q               <= pick_idx;
            beat_cnt_q            <= len_a[pick_idx];
            req_ready_q[pick_idx] <= 1'b1;
            awvalid_q             <= 1'b1;
            awaddr_q              <= addr_a[pick_idx];
            awlen_q               <= len_a[pick_idx];
            awburst_q             <= {1'b0, req_burst[pick_idx]};
            awid_q                <= IDWIDTH'(pick_idx);
          end
        end
        ADDR: begin
          if (AWREADY) awvalid_q <= 1'b0;
        end
        DATA: begin
          if (w_hs) beat_cnt_q <= beat_cnt_q - 4'd1;
        end
        RESP: begin
          if (BVALID) begin
            done_valid_q[grant_q] <= 1'b1;
            // A B carrying someone else's ID is reported as DECERR.
            done_resp_q           <= (BID == IDWIDTH'(grant_q)) ? BRESP : 2'b11;
            rr_ptr_q              <= grant_q;
          end else if (to_fire) begin
            done_valid_q[grant_q] <= 1'b1;
            done_resp_q           <= 2'b10;
            rr_ptr_q              <= grant_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;
  assign AWVALID    = awvalid_q;
  assign AWADDR     = awaddr_q;
  assign AWLEN      = awlen_q;
  assign AWBURST    = awburst_q;
  assign AWID       = awid_q;
  assign grant_idx  = grant_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
module tb_axi_wr_arbiter;
  localparam int NREQ    = 4;
  localparam int AWIDTH  = 32;
  localparam int DWIDTH  = 64;
  localparam int IDWIDTH = 4;
  localparam int TIMEOUT = 16;
  localparam int GW      = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*4-1:0]      req_len;
  logic [NREQ-1:0]        req_burst;
  logic [NREQ-1:0]        wr_valid;
  logic [NREQ*DWIDTH-1:0] wr_data;
  logic [NREQ-1:0]        wr_ready;
  logic [NREQ-1:0]        done_valid;
  logic [1:0]             done_resp;
  logic                   AWVALID, AWREADY;
  logic [AWIDTH-1:0]      AWADDR;
  logic [3:0]             AWLEN;
  logic [1:0]             AWBURST;
  logic [IDWIDTH-1:0]     AWID;
  logic                   WVALID, WREADY, WLAST;
  logic [DWIDTH-1:0]      WDATA;
  logic [IDWIDTH-1:0]     WID;
  logic                   BVALID, BREADY;
  logic [1:0]             BRESP;
  logic [IDWIDTH-1:0]     BID;
  logic                   busy;
  logic [GW-1:0]          grant_idx;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the requesters and of the rotation pointer
  bit          m_pend  [NREQ];
  logic [31:0] m_addr  [NREQ];
  logic [3:0]  m_len   [NREQ];
  bit          m_burst [NREQ];
  int          rr;

  axi_wr_arbiter #(.NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
                   .IDWIDTH(IDWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_burst(req_burst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .done_valid(done_valid), .done_resp(done_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST), .WID(WID),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                  = m_pend[i];
      req_addr[i*AWIDTH +: AWIDTH]  = m_addr[i];
      req_len[i*4 +: 4]             = m_len[i];
      req_burst[i]                  = m_burst[i];
    end
  endtask

  // Rotation rule: first pending requester after the last grant, with wrap.
  function automatic int next_grant();
    for (int k = 1; k <= NREQ; k++)
      if (m_pend[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit outs_zero();
    return ({req_ready, wr_ready, done_valid, done_resp, AWVALID, AWADDR, AWLEN,
             AWBURST, AWID, WVALID, WDATA, WLAST, WID, BREADY, busy, grant_idx} == '0);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      m_pend[i] = 0; m_addr[i] = '0; m_len[i] = '0; m_burst[i] = 0;
    end
    rr = NREQ - 1;
    apply_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  // Runs one transaction for expected grant g, playing the AXI slave.
  task automatic run_txn(input int g, input bit rnd, input int wstall_beat,
                         input bit bad_bid, input bit no_b, output int edges);
    int n, b, cyc, sl;
    bit got, wv, wrdy;
    logic [DWIDTH-1:0] d;
    logic [1:0] resp, exp_resp;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    edges = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick(); edges++;
      if (req_ready != '0) got = 1;
    end
    checks++;
    if (!got) begin
      $display("FAIL grant_wait: req_ready=%b, expected requester %0d granted within 20 cycles", req_ready, g);
      errors++;
      return;
    end
    checks++;
    if (req_ready !== oh || grant_idx !== GW'(g) || busy !== 1'b1) begin
      $display("FAIL grant: req_ready=%b grant_idx=%0d busy=%b, expected %b %0d 1", req_ready, grant_idx, busy, oh, g);
      errors++;
    end
    checks++;
    if ({AWVALID, AWADDR, AWLEN, AWBURST, AWID} !== {1'b1, m_addr[g], m_len[g], {1'b0, m_burst[g]}, IDWIDTH'(g)}) begin
      $display("FAIL aw_fields: valid=%b addr=%h len=%0d burst=%b id=%0d, expected 1 %h %0d %b %0d",
               AWVALID, AWADDR, AWLEN, AWBURST, AWID, m_addr[g], m_len[g], {1'b0, m_burst[g]}, g);
      errors++;
    end
    m_pend[g] = 0;
    apply_reqs();
    if (rnd) repeat ($urandom_range(0, 3)) begin
      tick(); edges++;
      checks++;
      if (AWVALID !== 1'b1 || req_ready !== '0) begin
        $display("FAIL aw_hold: AWVALID=%b req_ready=%b, expected 1 0", AWVALID, req_ready);
        errors++;
      end
    end
    AWREADY = 1'b1;
    tick(); edges++;
    AWREADY = 1'b0;
    checks++;
    if (AWVALID !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL aw_done: AWVALID=%b busy=%b, expected 0 1", AWVALID, busy);
      errors++;
    end
    n = int'(m_len[g]) + 1;
    b = 0; cyc = 0; sl = 5;
    while (b < n && cyc < 300) begin
      wv   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      wrdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (b == wstall_beat && sl > 0) begin wrdy = 1'b0; sl--; end
      d = {$urandom, $urandom};
      wr_valid = '0;
      wr_valid[g] = wv;
      wr_data[g*DWIDTH +: DWIDTH] = d;
      WREADY = wrdy;
      BVALID = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      BID = IDWIDTH'($urandom_range(0, NREQ - 1));
      #1;
      checks++;
      if (WVALID !== wv || WDATA !== d || WLAST !== (b == n - 1) || WID !== IDWIDTH'(g) ||
          wr_ready !== (wrdy ? oh : '0) || BREADY !== 1'b0 || done_valid !== '0) begin
        $display("FAIL w_beat %0d: WVALID=%b WDATA=%h WLAST=%b WID=%0d wr_ready=%b BREADY=%b, expected %b %h %b %0d %b 0",
                 b, WVALID, WDATA, WLAST, WID, wr_ready, BREADY, wv, d, (b == n - 1), g, (wrdy ? oh : '0));
        errors++;
      end
      tick(); edges++; cyc++;
      if (wv && wrdy) b++;
    end
    wr_valid = '0; WREADY = 1'b0; BVALID = 1'b0;
    checks++;
    if (b != n) begin
      $display("FAIL w_count: accepted %0d beats, expected %0d", b, n);
      errors++;
    end
    checks++;
    if (BREADY !== 1'b1 || WVALID !== 1'b0 || busy !== 1'b1 || done_valid !== '0) begin
      $display("FAIL resp_enter: BREADY=%b WVALID=%b busy=%b done=%b, expected 1 0 1 0", BREADY, WVALID, busy, done_valid);
      errors++;
    end
    if (no_b) begin
      cyc = 0; got = 0;
      while (!got && cyc < 40) begin
        tick(); cyc++; edges++;
        if (done_valid !== '0) got = 1;
      end
      checks++;
      if (!got || cyc != TIMEOUT || done_valid !== oh || done_resp !== 2'b10) begin
        $display("FAIL timeout: done after %0d cycles valid=%b resp=%b, expected %0d %b 10", cyc, done_valid, done_resp, TIMEOUT, oh);
        errors++;
      end
    end else begin
      if (rnd) repeat ($urandom_range(0, 4)) begin
        tick(); edges++;
        checks++;
        if (done_valid !== '0 || BREADY !== 1'b1) begin
          $display("FAIL resp_wait: done=%b BREADY=%b, expected 0 1", done_valid, BREADY);
          errors++;
        end
      end
      resp = 2'($urandom_range(0, 3));
      if (bad_bid || (rnd && $urandom_range(0, 3) == 0)) BID = IDWIDTH'((g + 1) % NREQ);
      else BID = IDWIDTH'(g);
      exp_resp = (int'(BID) == g) ? resp : 2'b11;
      BVALID = 1'b1;
      BRESP  = resp;
      tick(); edges++;
      BVALID = 1'b0;
      checks++;
      if (done_valid !== oh || done_resp !== exp_resp || busy !== 1'b0 || BREADY !== 1'b0) begin
        $display("FAIL done: valid=%b resp=%b busy=%b BREADY=%b, expected %b %b 0 0", done_valid, done_resp, busy, BREADY, oh, exp_resp);
        errors++;
      end
    end
    rr = g;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    wr_valid = '0; wr_data = '0; AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0; BID = '0;
    tick(); tick();
    checks++;
    if (!outs_zero()) begin
      $display("FAIL reset_hold: outputs not all zero during reset (busy=%b AWVALID=%b grant_idx=%0d)", busy, AWVALID, grant_idx);
      errors++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (!outs_zero()) begin
      $display("FAIL reset_release: outputs not all zero after reset (busy=%b AWVALID=%b grant_idx=%0d)", busy, AWVALID, grant_idx);
      errors++;
    end
  endtask

  task automatic test_single();
    int e;
    m_pend[0] = 1; m_addr[0] = 32'h100; m_len[0] = 4'd3; m_burst[0] = 1;
    apply_reqs();
    run_txn(0, 0, -1, 0, 0, e);
    checks++;
    if (e != 7) begin
      $display("FAIL latency: done after %0d cycles, expected 7", e);
      errors++;
    end
  endtask

  task automatic test_rotation();
    int e, g;
    do_reset();
    repeat (2) begin
      for (int i = 0; i < NREQ; i++) begin
        m_pend[i] = 1; m_addr[i] = $urandom; m_len[i] = 4'd0; m_burst[i] = 1'($urandom_range(0, 1));
      end
      apply_reqs();
      for (int k = 0; k < NREQ; k++) begin
        g = next_grant();
        run_txn(g, 0, -1, 0, 0, e);
      end
    end
  endtask

  task automatic test_wstall();
    int e;
    m_pend[2] = 1; m_addr[2] = 32'h2000; m_len[2] = 4'd7; m_burst[2] = 0;
    apply_reqs();
    run_txn(next_grant(), 0, 3, 0, 0, e);
  endtask

  task automatic test_bad_bid();
    int e;
    m_pend[1] = 1; m_addr[1] = 32'h3000; m_len[1] = 4'd1; m_burst[1] = 1;
    apply_reqs();
    run_txn(1, 0, -1, 1, 0, e);
  endtask

  task automatic test_reset_mid();
    int e;
    m_pend[0] = 1; m_addr[0] = 32'h400; m_len[0] = 4'd3; m_burst[0] = 1;
    apply_reqs();
    tick();
    m_pend[0] = 0; apply_reqs();
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    wr_valid = 4'b0001; WREADY = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!outs_zero()) begin
      $display("FAIL reset_mid: outputs not zero right after reset (busy=%b WVALID=%b wr_ready=%b AWADDR=%h)", busy, WVALID, wr_ready, AWADDR);
      errors++;
    end
    tick();
    rst = 1'b0; wr_valid = '0; WREADY = 1'b0;
    clear_model();
    BVALID = 1'b1; BID = '0; BRESP = '0;
    repeat (3) begin
      tick();
      checks++;
      if (done_valid !== '0 || busy !== 1'b0) begin
        $display("FAIL reset_no_done: done=%b busy=%b, expected 0 0", done_valid, busy);
        errors++;
      end
    end
    BVALID = 1'b0;
    m_pend[0] = 1; m_addr[0] = 32'h500; m_len[0] = 4'd2; m_burst[0] = 1;
    m_pend[2] = 1; m_addr[2] = 32'h600; m_len[2] = 4'd1; m_burst[2] = 0;
    apply_reqs();
    run_txn(next_grant(), 0, -1, 0, 0, e);
    run_txn(next_grant(), 0, -1, 0, 0, e);
  endtask

  task automatic test_random();
    int e, g, w;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!m_pend[i] && $urandom_range(0, 2) == 0) begin
          m_pend[i] = 1; m_addr[i] = $urandom; m_len[i] = 4'($urandom_range(0, 15));
          m_burst[i] = 1'($urandom_range(0, 1));
        end
      // Occasionally withdraw a request before it can be granted.
      if ($urandom_range(0, 4) == 0) begin
        w = $urandom_range(0, NREQ - 1);
        m_pend[w] = 0;
      end
      if (next_grant() < 0) begin
        w = $urandom_range(0, NREQ - 1);
        m_pend[w] = 1; m_addr[w] = $urandom; m_len[w] = 4'($urandom_range(0, 15));
        m_burst[w] = 1'($urandom_range(0, 1));
      end
      apply_reqs();
      g = next_grant();
      run_txn(g, 1, -1, 0, 0, e);
    end
    for (int i = 0; i < NREQ; i++) m_pend[i] = 0;
    apply_reqs();
  endtask

`ifdef AXI_WR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int e;
    m_pend[3] = 1; m_addr[3] = 32'h700; m_len[3] = 4'd1; m_burst[3] = 1;
    apply_reqs();
    run_txn(next_grant(), 0, -1, 0, 1, e);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wstall();
    test_bad_bid();
    test_reset_mid();
    test_random();
`ifdef AXI_WR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
